// File: rtl/ext_int_gen_if.sv
// ext_int_gen_if: core I/O bus, extended RAM bus and interrupt-acknowledge path
interface ext_int_gen_if;
    logic [5:0]  IO_Addr;
    logic        iore;
    logic        iowe;
    logic [11:0] ram_Addr;
    logic        ramre;
    logic        ramwe;
    logic [7:0]  dbus_in;
    logic [7:0]  dbus_out;
    logic        out_en;
    logic [5:0]  irqack_addr;
    logic        irqack;
    modport master (
        output IO_Addr, iore, iowe, ram_Addr, ramre, ramwe, dbus_in, irqack_addr, irqack,
        input  dbus_out, out_en
    );
    modport slave (
        input  IO_Addr, iore, iowe, ram_Addr, ramre, ramwe, dbus_in, irqack_addr, irqack,
        output dbus_out, out_en
    );
endinterface

// File: rtl/ext_int_gen.sv
// ext_int_gen: external (sense-configurable, optionally filtered) and pin-change interrupt controller
module ext_int_gen #(
    parameter int          NUM_INT        = 2,
    parameter int          NUM_PCGRP      = 4,
    parameter int          FILT_CYC       = 0,
    parameter logic [11:0] EICRA_Address  = 12'h069,
    parameter logic [11:0] EICRB_Address  = 12'h06A,
    parameter logic [11:0] PCICR_Address  = 12'h068,
    parameter logic [11:0] PCMSK0_Address = 12'h06B,
    parameter logic [5:0]  EIFR_Address   = 6'h1C,
    parameter logic [5:0]  EIMSK_Address  = 6'h1D,
    parameter logic [5:0]  PCIFR_Address  = 6'h1B,
    parameter logic [5:0]  EXT_IRQ_BASE   = 6'h01,
    parameter logic [5:0]  PC_IRQ_BASE    = 6'h03
) (
    input  logic                   cp2,
    input  logic                   ireset,
    ext_int_gen_if.slave           bus,
    input  logic [NUM_INT-1:0]     EXTINT,
    input  logic [8*NUM_PCGRP-1:0] PCIN,
    output logic [NUM_INT-1:0]     ExtIntIRQ,
    output logic [NUM_PCGRP-1:0]   PCIntIRQ,
    output logic [NUM_INT-1:0]     INT_EN,
    output logic [NUM_PCGRP-1:0]   PCIE,
    output logic [8*NUM_PCGRP-1:0] PCINT
);
    localparam logic [15:0] EICR_MASK = 16'((1 << (2 * NUM_INT)) - 1);

    logic [NUM_INT-1:0]            ext_s1_q, ext_s2_q, f_q, f_d, f_dly_q;
    logic [NUM_INT-1:0][7:0]       cnt_q, cnt_d;
    logic [8*NUM_PCGRP-1:0]        pc_s1_q, pc_s2_q, pc_s2_dly_q;
    logic [NUM_PCGRP-1:0]          pc_chg_q, pc_chg_d;
    logic [15:0]                   eicr_q, eicr_d;
    logic [NUM_INT-1:0]            eimsk_q, eimsk_d, eifr_q, eifr_d;
    logic [NUM_PCGRP-1:0]          pcicr_q, pcicr_d, pcifr_q, pcifr_d;
    logic [NUM_PCGRP-1:0][7:0]     pcmsk_q, pcmsk_d;
    logic [NUM_INT-1:0]            level, ext_set, ext_clr;
    logic [NUM_PCGRP-1:0]          pc_clr;
    logic                          wr_eifr, wr_pcifr;

    assign wr_eifr  = bus.iowe && bus.IO_Addr == EIFR_Address;
    assign wr_pcifr = bus.iowe && bus.IO_Addr == PCIFR_Address;

    // glitch filter: f follows s2 only after it has differed for FILT_CYC consecutive cycles
    always_comb begin
        f_d   = f_q;
        cnt_d = '0;
        for (int i = 0; i < NUM_INT; i++) begin
            if (FILT_CYC == 0)
                f_d[i] = ext_s2_q[i];
            else if (ext_s2_q[i] != f_q[i]) begin
                if (cnt_q[i] == 8'(FILT_CYC - 1))
                    f_d[i] = ext_s2_q[i];
                else
                    cnt_d[i] = cnt_q[i] + 8'd1;
            end
        end
    end

    // sense decode and external flag update (a hardware set beats a same-cycle clear)
    always_comb begin
        level   = '0;
        ext_set = '0;
        ext_clr = '0;
        eifr_d  = '0;
        for (int i = 0; i < NUM_INT; i++) begin
            level[i]   = eicr_q[2*i +: 2] == 2'b00;
            ext_set[i] = (eicr_q[2*i +: 2] == 2'b01) ? f_q[i] ^ f_dly_q[i] :
                         (eicr_q[2*i +: 2] == 2'b10) ? ~f_q[i] & f_dly_q[i] :
                         (eicr_q[2*i +: 2] == 2'b11) ? f_q[i] & ~f_dly_q[i] : 1'b0;
            ext_clr[i] = (wr_eifr && bus.dbus_in[i]) ||
                         (bus.irqack && bus.irqack_addr == EXT_IRQ_BASE + 6'(i));
            eifr_d[i]  = ext_set[i] | (eifr_q[i] & ~ext_clr[i]);
        end
    end

    // pin-change detect on masked synchronised pins and group flag update
    always_comb begin
        pc_chg_d = '0;
        pc_clr   = '0;
        pcifr_d  = '0;
        for (int g = 0; g < NUM_PCGRP; g++) begin
            pc_chg_d[g] = |((pc_s2_q[8*g +: 8] ^ pc_s2_dly_q[8*g +: 8]) & pcmsk_q[g]);
            pc_clr[g]   = (wr_pcifr && bus.dbus_in[g]) ||
                          (bus.irqack && bus.irqack_addr == PC_IRQ_BASE + 6'(g));
            pcifr_d[g]  = pc_chg_q[g] | (pcifr_q[g] & ~pc_clr[g]);
        end
    end

    // control and mask register writes; unimplemented bits are dropped
    always_comb begin
        eicr_d = eicr_q;
        if (bus.ramwe && bus.ram_Addr == EICRA_Address)
            eicr_d[7:0] = bus.dbus_in;
        if (NUM_INT > 4 && bus.ramwe && bus.ram_Addr == EICRB_Address)
            eicr_d[15:8] = bus.dbus_in;
        eicr_d  = eicr_d & EICR_MASK;
        eimsk_d = (bus.iowe && bus.IO_Addr == EIMSK_Address) ? bus.dbus_in[NUM_INT-1:0] : eimsk_q;
        pcicr_d = (bus.ramwe && bus.ram_Addr == PCICR_Address) ? bus.dbus_in[NUM_PCGRP-1:0] : pcicr_q;
        for (int g = 0; g < NUM_PCGRP; g++)
            pcmsk_d[g] = (bus.ramwe && bus.ram_Addr == PCMSK0_Address + 12'(g)) ? bus.dbus_in : pcmsk_q[g];
    end

    // read mux: I/O space wins over RAM space; level-mode lines always read 0 in EIFR
    always_comb begin
        bus.dbus_out = 8'd0;
        bus.out_en   = 1'b0;
        if (bus.iore) begin
            if (bus.IO_Addr == EIFR_Address) begin
                bus.dbus_out = 8'(eifr_q & ~level);
                bus.out_en   = 1'b1;
            end else if (bus.IO_Addr == EIMSK_Address) begin
                bus.dbus_out = 8'(eimsk_q);
                bus.out_en   = 1'b1;
            end else if (bus.IO_Addr == PCIFR_Address) begin
                bus.dbus_out = 8'(pcifr_q);
                bus.out_en   = 1'b1;
            end
        end else if (bus.ramre) begin
            if (bus.ram_Addr == EICRA_Address) begin
                bus.dbus_out = eicr_q[7:0];
                bus.out_en   = 1'b1;
            end else if (NUM_INT > 4 && bus.ram_Addr == EICRB_Address) begin
                bus.dbus_out = eicr_q[15:8];
                bus.out_en   = 1'b1;
            end else if (bus.ram_Addr == PCICR_Address) begin
                bus.dbus_out = 8'(pcicr_q);
                bus.out_en   = 1'b1;
            end
            for (int g = 0; g < NUM_PCGRP; g++)
                if (bus.ram_Addr == PCMSK0_Address + 12'(g)) begin
                    bus.dbus_out = pcmsk_q[g];
                    bus.out_en   = 1'b1;
                end
        end
    end

    // state registers, all cleared asynchronously
    always_ff @(posedge cp2 or posedge ireset)
        if (ireset) begin
            ext_s1_q    <= '0;
            ext_s2_q    <= '0;
            f_q         <= '0;
            f_dly_q     <= '0;
            cnt_q       <= '0;
            pc_s1_q     <= '0;
            pc_s2_q     <= '0;
            pc_s2_dly_q <= '0;
            pc_chg_q    <= '0;
            eicr_q      <= '0;
            eimsk_q     <= '0;
            eifr_q      <= '0;
            pcicr_q     <= '0;
            pcifr_q     <= '0;
            pcmsk_q     <= '0;
        end else begin
            ext_s1_q    <= EXTINT;
            ext_s2_q    <= ext_s1_q;
            f_q         <= f_d;
            f_dly_q     <= f_q;
            cnt_q       <= cnt_d;
            pc_s1_q     <= PCIN;
            pc_s2_q     <= pc_s1_q;
            pc_s2_dly_q <= pc_s2_q;
            pc_chg_q    <= pc_chg_d;
            eicr_q      <= eicr_d;
            eimsk_q     <= eimsk_d;
            eifr_q      <= eifr_d;
            pcicr_q     <= pcicr_d;
            pcifr_q     <= pcifr_d;
            pcmsk_q     <= pcmsk_d;
        end

    assign ExtIntIRQ = eimsk_q & ((level & ~f_q) | (~level & eifr_q));
    assign PCIntIRQ  = pcifr_q & pcicr_q;
    assign INT_EN    = eimsk_q;
    assign PCIE      = pcicr_q;
    assign PCINT     = pcmsk_q;
endmodule

// File: tb/tb_ext_int_gen.sv
// tb_ext_int_gen: directed checks of ext_int_gen with unfiltered (dut0) and 4-cycle filtered (dut4) instances
module tb_ext_int_gen;
    localparam logic [11:0] A_EIFR  = 12'h01C;
    localparam logic [11:0] A_EIMSK = 12'h01D;
    localparam logic [11:0] A_PCIFR = 12'h01B;
    localparam logic [11:0] A_EICRA = 12'h069;
    localparam logic [11:0] A_EICRB = 12'h06A;
    localparam logic [11:0] A_PCICR = 12'h068;
    localparam logic [11:0] A_PCMSK0 = 12'h06B;

    typedef struct {
        bit          io;
        logic [11:0] addr;
        bit          wr;
        logic [7:0]  wdata;
        logic [7:0]  exp_d;
        bit          exp_en;
    } vec_t;

    logic        cp2 = 1'b0;
    logic        ireset;
    logic [1:0]  EXTINT;
    logic [31:0] PCIN;
    logic [1:0]  irq0, irq4, inten0, inten4;
    logic [3:0]  pcirq0, pcirq4, pcie0, pcie4;
    logic [31:0] pcint0, pcint4;
    logic [7:0]  d0, d4;
    logic        e0;
    int          checks = 0;
    int          errors = 0;
    vec_t        vt [17];

    ext_int_gen_if bus0 ();
    ext_int_gen_if bus4 ();

    assign bus4.IO_Addr     = bus0.IO_Addr;
    assign bus4.iore        = bus0.iore;
    assign bus4.iowe        = bus0.iowe;
    assign bus4.ram_Addr    = bus0.ram_Addr;
    assign bus4.ramre       = bus0.ramre;
    assign bus4.ramwe       = bus0.ramwe;
    assign bus4.dbus_in     = bus0.dbus_in;
    assign bus4.irqack_addr = bus0.irqack_addr;
    assign bus4.irqack      = bus0.irqack;

    ext_int_gen #(.FILT_CYC(0)) dut0 (
        .cp2(cp2), .ireset(ireset), .bus(bus0.slave), .EXTINT(EXTINT), .PCIN(PCIN),
        .ExtIntIRQ(irq0), .PCIntIRQ(pcirq0), .INT_EN(inten0), .PCIE(pcie0), .PCINT(pcint0)
    );

    ext_int_gen #(.FILT_CYC(4)) dut4 (
        .cp2(cp2), .ireset(ireset), .bus(bus4.slave), .EXTINT(EXTINT), .PCIN(PCIN),
        .ExtIntIRQ(irq4), .PCIntIRQ(pcirq4), .INT_EN(inten4), .PCIE(pcie4), .PCINT(pcint4)
    );

    always #5 cp2 = ~cp2;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge cp2);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic wr(input bit io, input logic [11:0] a, input logic [7:0] d);
        bus0.dbus_in = d;
        if (io) begin
            bus0.IO_Addr = a[5:0];
            bus0.iowe    = 1'b1;
        end else begin
            bus0.ram_Addr = a;
            bus0.ramwe    = 1'b1;
        end
        tick(1);
        bus0.iowe  = 1'b0;
        bus0.ramwe = 1'b0;
    endtask

    task automatic rd(input bit io, input logic [11:0] a);
        if (io) begin
            bus0.IO_Addr = a[5:0];
            bus0.iore    = 1'b1;
        end else begin
            bus0.ram_Addr = a;
            bus0.ramre    = 1'b1;
        end
        #1;
        d0 = bus0.dbus_out;
        d4 = bus4.dbus_out;
        e0 = bus0.out_en;
        bus0.iore  = 1'b0;
        bus0.ramre = 1'b0;
    endtask

    task automatic ack(input logic [5:0] v);
        bus0.irqack_addr = v;
        bus0.irqack      = 1'b1;
        tick(1);
        bus0.irqack = 1'b0;
    endtask

    initial begin
        vt[0]  = '{1'b1, A_EIFR,          1'b0, 8'h00, 8'h00, 1'b1};
        vt[1]  = '{1'b1, A_EIMSK,         1'b0, 8'h00, 8'h00, 1'b1};
        vt[2]  = '{1'b1, A_PCIFR,         1'b0, 8'h00, 8'h00, 1'b1};
        vt[3]  = '{1'b0, A_EICRA,         1'b0, 8'h00, 8'h00, 1'b1};
        vt[4]  = '{1'b0, A_PCICR,         1'b0, 8'h00, 8'h00, 1'b1};
        vt[5]  = '{1'b0, A_PCMSK0,        1'b0, 8'h00, 8'h00, 1'b1};
        vt[6]  = '{1'b0, A_PCMSK0 + 12'd1, 1'b0, 8'h00, 8'h00, 1'b1};
        vt[7]  = '{1'b0, A_PCMSK0 + 12'd2, 1'b0, 8'h00, 8'h00, 1'b1};
        vt[8]  = '{1'b0, A_PCMSK0 + 12'd3, 1'b0, 8'h00, 8'h00, 1'b1};
        vt[9]  = '{1'b0, A_EICRB,         1'b0, 8'h00, 8'h00, 1'b0};
        vt[10] = '{1'b1, 12'h01E,         1'b0, 8'h00, 8'h00, 1'b0};
        vt[11] = '{1'b0, A_EICRA,         1'b1, 8'hFF, 8'h0F, 1'b1};
        vt[12] = '{1'b1, A_EIMSK,         1'b1, 8'hFF, 8'h03, 1'b1};
        vt[13] = '{1'b0, A_PCICR,         1'b1, 8'hFF, 8'h0F, 1'b1};
        vt[14] = '{1'b0, A_PCMSK0 + 12'd3, 1'b1, 8'hA5, 8'hA5, 1'b1};
        vt[15] = '{1'b0, A_EICRB,         1'b1, 8'hFF, 8'h00, 1'b0};
        vt[16] = '{1'b0, A_PCMSK0 + 12'd4, 1'b1, 8'h55, 8'h00, 1'b0};

        ireset = 1'b1;
        EXTINT = 2'b00;
        PCIN   = '0;
        bus0.IO_Addr = '0; bus0.iore = 1'b0; bus0.iowe = 1'b0;
        bus0.ram_Addr = '0; bus0.ramre = 1'b0; bus0.ramwe = 1'b0;
        bus0.dbus_in = '0; bus0.irqack_addr = '0; bus0.irqack = 1'b0;
        tick(3);
        ireset = 1'b0;
        tick(1);

        chk("reset outputs", {irq0, pcirq0, inten0, pcie0, pcint0}, 64'h0);
        for (int k = 0; k < 17; k++) begin
            if (vt[k].wr) wr(vt[k].io, vt[k].addr, vt[k].wdata);
            rd(vt[k].io, vt[k].addr);
            chk($sformatf("reg data %0d", k), d0, vt[k].exp_d);
            chk($sformatf("reg en %0d", k), e0, vt[k].exp_en);
            tick(1);
        end
        chk("INT_EN", inten0, 2'b11);
        chk("PCIE", pcie0, 4'hF);
        chk("PCINT", pcint0, 32'hA500_0000);
        wr(1, A_EIMSK, 8'h00);
        wr(0, A_EICRA, 8'h00);
        wr(0, A_PCICR, 8'h00);
        wr(0, A_PCMSK0 + 12'd3, 8'h00);
        chk("PCINT cleared", pcint0, 32'h0);

        // rising edge on line 0, any-change on line 1
        wr(0, A_EICRA, 8'h07);
        wr(1, A_EIMSK, 8'h01);
        EXTINT = 2'b01;
        tick(3);
        chk("rise irq edge3", irq0, 2'b00);
        tick(1);
        chk("rise irq edge4", irq0, 2'b01);
        rd(1, A_EIFR);
        chk("rise eifr", d0, 8'h01);
        wr(1, A_EIFR, 8'h02);
        rd(1, A_EIFR);
        chk("w1c other bit", d0, 8'h01);
        ack(6'h02);
        chk("ack other vector", irq0, 2'b01);
        ack(6'h01);
        chk("ack irq", irq0, 2'b00);
        rd(1, A_EIFR);
        chk("ack eifr", d0, 8'h00);
        EXTINT = 2'b11;
        tick(4);
        rd(1, A_EIFR);
        chk("change up eifr", d0, 8'h02);
        chk("unmasked flag no irq", irq0, 2'b00);
        wr(1, A_EIFR, 8'h02);
        rd(1, A_EIFR);
        chk("w1c line1", d0, 8'h00);
        EXTINT = 2'b01;
        tick(4);
        rd(1, A_EIFR);
        chk("change down eifr", d0, 8'h02);
        wr(0, A_EICRA, 8'h0F);
        rd(1, A_EIFR);
        chk("sense change keeps flag", d0, 8'h02);
        wr(1, A_EIFR, 8'h02);

        // filtered falling edge on dut4
        tick(8);
        wr(0, A_EICRA, 8'h02);
        wr(1, A_EIFR, 8'hFF);
        rd(1, A_EIFR);
        chk("filt start clear", d4, 8'h00);
        EXTINT = 2'b00;
        tick(3);
        EXTINT = 2'b01;
        tick(12);
        rd(1, A_EIFR);
        chk("filt 3-cycle pulse", d4, 8'h00);
        wr(1, A_EIFR, 8'hFF);
        EXTINT = 2'b00;
        tick(4);
        EXTINT = 2'b01;
        tick(2);
        rd(1, A_EIFR);
        chk("filt edge6", d4, 8'h00);
        tick(1);
        rd(1, A_EIFR);
        chk("filt edge7", d4, 8'h01);
        chk("filt irq edge7", irq4, 2'b01);
        tick(10);
        wr(1, A_EIFR, 8'hFF);
        rd(1, A_EIFR);
        chk("pre set-wins dut4", d4, 8'h00);
        EXTINT = 2'b00;
        tick(6);
        wr(1, A_EIFR, 8'h01);
        rd(1, A_EIFR);
        chk("set wins dut4", d4, 8'h01);
        chk("w1c clears dut0", d0, 8'h00);

        // low-level sense on dut0
        wr(0, A_EICRA, 8'h00);
        chk("level irq", irq0, 2'b01);
        rd(1, A_EIFR);
        chk("level eifr dut0", d0, 8'h00);
        chk("level eifr dut4", d4, 8'h00);
        ack(6'h01);
        chk("level irq after ack", irq0, 2'b01);
        EXTINT = 2'b01;
        tick(2);
        chk("level release edge2", irq0, 2'b01);
        tick(1);
        chk("level release edge3", irq0, 2'b00);
        rd(1, A_EIFR);
        chk("level release eifr", d0, 8'h00);

        // pin change group 1, pin 2
        wr(0, A_PCMSK0 + 12'd1, 8'h04);
        wr(0, A_PCICR, 8'h02);
        chk("PCINT grp1", pcint0, 32'h0000_0400);
        chk("PCIE grp1", pcie0, 4'h2);
        PCIN = 32'h0000_0400;
        tick(3);
        chk("pc irq edge3", pcirq0, 4'h0);
        tick(1);
        chk("pc irq edge4", pcirq0, 4'h2);
        rd(1, A_PCIFR);
        chk("pcifr set", d0, 8'h02);
        wr(1, A_PCIFR, 8'h02);
        rd(1, A_PCIFR);
        chk("pcifr w1c", d0, 8'h00);
        PCIN = 32'h0;
        tick(4);
        rd(1, A_PCIFR);
        chk("pcifr falling toggle", d0, 8'h02);
        ack(6'h04);
        rd(1, A_PCIFR);
        chk("pcifr ack", d0, 8'h00);
        chk("pc irq ack", pcirq0, 4'h0);
        PCIN = 32'h0000_0200;
        tick(6);
        rd(1, A_PCIFR);
        chk("unmasked pin", d0, 8'h00);
        chk("unmasked pin irq", pcirq0, 4'h0);

        // asynchronous reset with dut4 filter counter at 2 and flags pending
        wr(0, A_EICRA, 8'h02);
        EXTINT = 2'b00;
        PCIN   = 32'h0000_0600;
        tick(4);
        chk("pre-reset ext irq", irq0, 2'b01);
        chk("pre-reset pc irq", pcirq0, 4'h2);
        ireset = 1'b1;
        #1;
        chk("async rst dut0", {irq0, pcirq0, inten0, pcie0, pcint0}, 64'h0);
        chk("async rst dut4", {irq4, pcirq4, inten4, pcie4, pcint4}, 64'h0);
        tick(2);
        ireset = 1'b0;
        wr(0, A_EICRA, 8'h02);
        wr(1, A_EIMSK, 8'h01);
        tick(12);
        rd(1, A_EIFR);
        chk("post-rst low dut0", d0, 8'h00);
        chk("post-rst low dut4", d4, 8'h00);
        chk("post-rst irq dut4", irq4, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ext_int_gen.md
Name: ext_int_gen

Overview:
Parametrised external/pin-change interrupt controller for the AVR-compatible core. It supports NUM_INT sense-configurable external interrupt lines with an optional per-line digital glitch filter, and NUM_PCGRP 8-bit pin-change groups. Each source gets a flag, a mask and an IRQ, plus an acknowledge path. The block sits on the core's I/O bus (flags, EIMSK) and extended RAM-mapped bus (control and mask registers).

Parameters:
NUM_INT, 2, number of external interrupt lines (1..8)
NUM_PCGRP, 4, number of pin-change groups (1..8), 8 pins each
FILT_CYC, 0, glitch-filter length in cp2 cycles (0 = bypass, max 255)
EICRA_Address, 12'h069, RAM address of sense control for lines 0-3
EICRB_Address, 12'h06A, RAM address of sense control for lines 4-7 (decoded only if NUM_INT>4)
PCICR_Address, 12'h068, RAM address of pin-change group enables
PCMSK0_Address, 12'h06B, RAM address of group 0 mask; group g is at PCMSK0_Address+g
EIFR_Address, 6'h1C, I/O address of external flags
EIMSK_Address, 6'h1D, I/O address of external masks
PCIFR_Address, 6'h1B, I/O address of pin-change flags
EXT_IRQ_BASE, 6'h01, vector address of line 0; line i = base+i
PC_IRQ_BASE, 6'h03, vector address of group 0; group g = base+g (must not overlap the external vectors)

Ports:
cp2  in  1  system clock, all logic on rising edge
ireset  in  1  asynchronous reset, active-high
IO_Addr  in  6  I/O address
iore  in  1  I/O read strobe
iowe  in  1  I/O write strobe
ram_Addr  in  12  extended address
ramre  in  1  RAM read strobe
ramwe  in  1  RAM write strobe
dbus_in  in  8  write data
dbus_out  out  8  read data (combinational)
out_en  out  1  read hit (combinational)
irqack_addr  in  6  acknowledged vector
irqack  in  1  acknowledge strobe
EXTINT  in  NUM_INT  external interrupt pins (asynchronous)
PCIN  in  8*NUM_PCGRP  pin-change pins (asynchronous)
ExtIntIRQ  out  NUM_INT  per-line interrupt request
PCIntIRQ  out  NUM_PCGRP  per-group interrupt request
INT_EN  out  NUM_INT  EIMSK bits, for port override
PCIE  out  NUM_PCGRP  PCICR bits
PCINT  out  8*NUM_PCGRP  concatenated PCMSK bits

Behaviour:
- Reset: all registers, synchronisers, filter counters and filtered states are 0. All outputs are 0. Filtered state is 0, so no edge is flagged until the first stable sample.
- Register widths: unimplemented bits (beyond NUM_INT, NUM_PCGRP or 2*channels) ignore writes and read 0.
- Synchronisers: EXTINT and PCIN each pass through a 2-flop synchroniser (s1, s2).
- Filter, FILT_CYC>0, per line:
  - An 8-bit counter runs while s2 differs from the filtered value f.
  - It clears to 0 whenever s2 equals f.
  - When the counter reaches FILT_CYC-1 while still differing, f takes s2 and the counter clears.
  - Result: a pulse shorter than FILT_CYC cycles never changes f.
  - With FILT_CYC=0, f is s2 registered once.
- Edge detect: f_d is f delayed by one cycle. Sense per line is 2 bits in EICR[2i+1:2i]:
  - 00: low level
  - 01: any change
  - 10: falling edge
  - 11: rising edge
- Edge modes (01/10/11): a detected edge sets EIFR[i] on the next edge.
  - EIFR[i] clears on an acknowledge (irqack with irqack_addr = EXT_IRQ_BASE+i), or on an I/O write to EIFR with dbus_in[i]=1 (write-1-to-clear).
  - A hardware set and a clear in the same cycle: set wins, flag stays 1.
- Level mode (00): EIFR[i] is never set and reads 0. ExtIntIRQ[i] = ~f & EIMSK[i], so it stays asserted while the pin is low; acknowledge has no effect.
- Edge modes: ExtIntIRQ[i] = EIFR[i] & EIMSK[i]. Flags set regardless of the mask.
- Sense change: rewriting EICR does not clear an existing flag.
- Pin change:
  - pc_chg[g] = OR over p of ((s2 ^ s2_d)[8g+p] & PCMSKg[p]); it is registered once and sets PCIFR[g].
  - Clear rules and set-wins priority are the same as EIFR, with vector PC_IRQ_BASE+g.
  - PCIntIRQ[g] = PCIFR[g] & PCICR[g].
- Latency, pin to IRQ (mask already enabled), counting the first cp2 edge that samples the new level as edge 1:
  - External edge, FILT_CYC=0: flag and IRQ are high after edge 4.
  - External edge, FILT_CYC=N: flag and IRQ are high after edge 3+N.
  - Pin change: flag and IRQ are high after edge 4.
- Reads: I/O decode takes precedence when iore is asserted. Otherwise RAM decode applies when ramre is asserted. A miss gives dbus_out=0 and out_en=0.
- Reset mid-filter: the counter is discarded, and after release the pin is re-evaluated from f=0.

Test Plan:
1. Reset, then read every register: each returns 0 with out_en=1; IRQ, INT_EN, PCIE and PCINT are all 0.
2. EICRA=0x03 (line 0 rising), EIMSK=0x01, EXTINT[0] 0->1: ExtIntIRQ[0]=1 after edge 4 and EIFR reads 0x01. Then irqack with addr 0x01: flag and IRQ are 0 the next cycle.
3. FILT_CYC=4, falling sense: a low pulse of 3 cycles gives no flag; a low pulse of 4 cycles sets EIFR[0] at edge 7. Write EIFR=0x01 with a new edge in the same cycle: flag stays 1.
4. EICRA=0x00, EIMSK=0x01, hold EXTINT[0] low: IRQ stays high across an ack. Release high: IRQ drops 3 edges later and EIFR reads 0.
5. PCMSK1=0x04, PCICR=0x02, toggle PCIN[10]: PCIFR=0x02 and PCIntIRQ[1]=1 at edge 4. Toggle PCIN[9] (unmasked): no flag.
6. Assert ireset while the filter counter is at 2 and while flags are set: all outputs 0 immediately (async). After release, a held low level is not flagged as a falling edge.
